// File: rtl/rx_os_checker_array_pkg.sv
// Shared definitions for the RX ordered-set checker array: LTSSM substate
// encodings, OS type codes, per-lane OS payload and the legality table.
package rx_os_checker_array_pkg;

  localparam int unsigned substateWidth = 4;
  localparam int unsigned countWidth    = 5;
  localparam int unsigned numWidth      = 8;
  localparam logic [countWidth-1:0] countMax = {countWidth{1'b1}};

  typedef enum logic [substateWidth-1:0] {
    detectQuiet          = 4'd0,
    detectActive         = 4'd1,
    pollingActive        = 4'd2,
    pollingConfiguration = 4'd3,
    cfgLinkWidthStart    = 4'd4,
    cfgLinkWidthAccept   = 4'd5,
    cfgLanenumWait       = 4'd6,
    cfgLanenumAccept     = 4'd7,
    cfgComplete          = 4'd8,
    cfgIdle              = 4'd9
  } substateT;

  typedef enum logic [1:0] {
    osOther = 2'b00,
    osTs1   = 2'b01,
    osTs2   = 2'b10,
    osEios  = 2'b11
  } osTypeT;

  // Pad flags are 1 when the corresponding number field carries PAD.
  typedef struct packed {
    logic [1:0]          osType;
    logic                linkPad;
    logic                lanePad;
    logic [numWidth-1:0] linkNum;
    logic [numWidth-1:0] laneNum;
  } osFieldsT;

  // Legality of one ordered set for the given substate (type and pad checks).
  function automatic logic osMatches(input logic [substateWidth-1:0] substate,
                                     input logic [1:0] osType,
                                     input logic linkPad,
                                     input logic lanePad);
    logic isTs1;
    logic isTs2;
    logic result;
    isTs1  = (osType == osTs1);
    isTs2  = (osType == osTs2);
    result = 1'b0;
    case (substate)
      pollingActive:        result = (isTs1 || isTs2) && linkPad && lanePad;
      pollingConfiguration: result = isTs2 && linkPad && lanePad;
      cfgLinkWidthStart,
      cfgLinkWidthAccept:   result = isTs1 && !linkPad && lanePad;
      cfgLanenumWait:       result = isTs1 && !linkPad && !lanePad;
      cfgLanenumAccept:     result = (isTs1 || isTs2) && !linkPad && !lanePad;
      cfgComplete:          result = isTs2 && !linkPad && !lanePad;
      default:              result = 1'b0;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/rx_os_checker_array_lane.sv
// One lane checker: consecutive identical-OS counter, reference fields and
// registered threshold comparator.
module rx_lane_os_counter
  import rx_os_checker_array_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  substateChange,
  input  logic                  osValid,
  input  logic                  osMatch,
  input  osFieldsT              osFields,
  input  logic [countWidth-1:0] comparatorsCount,
  output logic                  comparator,
  output logic [numWidth-1:0]   rxLinkNum,
  output logic [numWidth-1:0]   rxLaneNum
);

  logic [countWidth-1:0] count;
  logic [countWidth-1:0] countNext;
  logic                  refValid;
  logic                  refValidNext;
  osFieldsT              refFields;
  osFieldsT              refFieldsNext;
  logic                  clearLane;
  logic                  identical;

  // Clear beats everything; otherwise a pulse restarts, extends or resets the run.
  always_comb begin
    countNext     = count;
    refValidNext  = refValid;
    refFieldsNext = refFields;
    clearLane     = !enable || substateChange;
    identical     = refValid && (osFields == refFields);
    if (clearLane) begin
      countNext    = '0;
      refValidNext = 1'b0;
    end else if (osValid) begin
      if (!osMatch) begin
        countNext = '0;
      end else if (identical) begin
        if (count != countMax) countNext = count + countWidth'(1);
      end else begin
        countNext     = countWidth'(1);
        refValidNext  = 1'b1;
        refFieldsNext = osFields;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count      <= '0;
      refValid   <= 1'b0;
      refFields  <= '0;
      comparator <= 1'b0;
    end else begin
      count      <= countNext;
      refValid   <= refValidNext;
      refFields  <= refFieldsNext;
      comparator <= enable && (countNext >= comparatorsCount);
    end
  end

  // Reference fields survive clears, so the reported numbers hold too.
  assign rxLinkNum = refFields.linkNum;
  assign rxLaneNum = refFields.laneNum;

endmodule

// File: rtl/rx_os_checker_array.sv
// Per-lane RX ordered-set checkers feeding the master RX LTSSM: substate-change
// detect, lane slicing and shared match decode around MAXLANES lane counters.
module rx_os_checker_array
  import rx_os_checker_array_pkg::*;
#(
  parameter int unsigned MAXLANES = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [substateWidth-1:0]     substate,
  input  logic [countWidth-1:0]        comparatorsCount,
  input  logic [MAXLANES-1:0]          resetOsCheckers,
  input  logic [MAXLANES-1:0]          osValid,
  input  logic [2*MAXLANES-1:0]        osType,
  input  logic [MAXLANES-1:0]          osLinkPad,
  input  logic [MAXLANES-1:0]          osLanePad,
  input  logic [numWidth*MAXLANES-1:0] osLinkNum,
  input  logic [numWidth*MAXLANES-1:0] osLaneNum,
  output logic [MAXLANES-1:0]          countersComparators,
  output logic [numWidth*MAXLANES-1:0] rxLinkNum,
  output logic [numWidth*MAXLANES-1:0] rxLaneNum
);

  logic [substateWidth-1:0] substateQ;
  logic                     substateChange;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) substateQ <= '0;
    else        substateQ <= substate;
  end

  assign substateChange = (substate != substateQ);

  for (genvar g = 0; g < MAXLANES; g++) begin : genLane
    osFieldsT laneFields;
    logic     laneMatch;

    assign laneFields = {osType[2*g +: 2], osLinkPad[g], osLanePad[g],
                         osLinkNum[numWidth*g +: numWidth],
                         osLaneNum[numWidth*g +: numWidth]};
    assign laneMatch  = osMatches(substate, osType[2*g +: 2], osLinkPad[g], osLanePad[g]);

    rx_lane_os_counter uLane (
      .clk              (clk),
      .reset            (reset),
      .enable           (resetOsCheckers[g]),
      .substateChange   (substateChange),
      .osValid          (osValid[g]),
      .osMatch          (laneMatch),
      .osFields         (laneFields),
      .comparatorsCount (comparatorsCount),
      .comparator       (countersComparators[g]),
      .rxLinkNum        (rxLinkNum[numWidth*g +: numWidth]),
      .rxLaneNum        (rxLaneNum[numWidth*g +: numWidth])
    );
  end

endmodule

// File: tb/tb_rx_os_checker_array.sv
// Scenario bench for rx_os_checker_array: each drive pushes the expected
// outputs, each test pops and compares after the edge.
module tb_rx_os_checker_array;

  localparam int unsigned Lanes = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   substate;
  logic [4:0]   comparatorsCount;
  logic [15:0]  resetOsCheckers;
  logic [15:0]  osValid;
  logic [31:0]  osType;
  logic [15:0]  osLinkPad;
  logic [15:0]  osLanePad;
  logic [127:0] osLinkNum;
  logic [127:0] osLaneNum;
  logic [15:0]  countersComparators;
  logic [127:0] rxLinkNum;
  logic [127:0] rxLaneNum;

  typedef struct {
    logic [15:0] comp;
    logic [7:0]  link;
    logic [7:0]  lane;
  } expT;

  expT         sbQ[$];
  expT         e;
  int          passed = 0;
  int          total  = 0;
  logic [15:0] laneMask;

  rx_os_checker_array #(.MAXLANES(Lanes)) dut (
    .clk                 (clk),
    .reset               (reset),
    .substate            (substate),
    .comparatorsCount    (comparatorsCount),
    .resetOsCheckers     (resetOsCheckers),
    .osValid             (osValid),
    .osType              (osType),
    .osLinkPad           (osLinkPad),
    .osLanePad           (osLanePad),
    .osLinkNum           (osLinkNum),
    .osLaneNum           (osLaneNum),
    .countersComparators (countersComparators),
    .rxLinkNum           (rxLinkNum),
    .rxLaneNum           (rxLaneNum)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // One clock of stimulus on the lanes in laneMask; expected outputs queued.
  task automatic drive(input logic v, input logic [15:0] en, input logic [1:0] typ,
                       input logic lkPad, input logic lnPad,
                       input logic [7:0] lk, input logic [7:0] ln,
                       input logic [15:0] xComp, input logic [7:0] xLink, input logic [7:0] xLane);
    resetOsCheckers = en;
    osValid   = v ? laneMask : 16'h0;
    osType    = {Lanes{typ}};
    osLinkPad = {Lanes{lkPad}};
    osLanePad = {Lanes{lnPad}};
    osLinkNum = {Lanes{lk}};
    osLaneNum = {Lanes{ln}};
    sbQ.push_back('{xComp, xLink, xLane});
    @(posedge clk);
    #1;
    osValid = 16'h0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    substate = 4'd0;
    comparatorsCount = 5'd0;
    laneMask = 16'h0001;
    resetOsCheckers = 16'h0;
    osValid = 16'h0;
    osType = '0; osLinkPad = '0; osLanePad = '0; osLinkNum = '0; osLaneNum = '0;
    #3;
    total++;
    if ({countersComparators, rxLinkNum, rxLaneNum} !== 272'b0)
      $display("FAIL reset_async: comp=%h link=%h lane=%h, expected all zero", countersComparators, rxLinkNum, rxLaneNum);
    else passed++;
    resetOsCheckers = 16'hFFFF;
    osValid = 16'hFFFF;
    osType = {Lanes{2'b01}}; osLinkPad = '1; osLanePad = '1;
    @(posedge clk);
    #1;
    total++;
    if ({countersComparators, rxLinkNum, rxLaneNum} !== 272'b0)
      $display("FAIL reset_held: comp=%h link=%h lane=%h, expected all zero", countersComparators, rxLinkNum, rxLaneNum);
    else passed++;
    osValid = 16'h0;
    resetOsCheckers = 16'h0;
    reset = 1'b1;
  endtask

  task automatic test_threshold();
    substate = 4'd2;
    comparatorsCount = 5'd8;
    for (int k = 0; k <= 10; k++) begin
      if (k < 2 || k == 10) drive(1'b0, 16'h1, 2'b00, 1'b0, 1'b0, 8'd0, 8'd0, {15'b0, k == 10}, 8'd0, 8'd0);
      else                  drive(1'b1, 16'h1, 2'b01, 1'b1, 1'b1, 8'd0, 8'd0, {15'b0, k == 9}, 8'd0, 8'd0);
      e = sbQ.pop_front();
      total++;
      if ({countersComparators, rxLinkNum, rxLaneNum} !== {e.comp, 120'b0, e.link, 120'b0, e.lane})
        $display("FAIL threshold step %0d: comp=%h link=%h lane=%h, expected comp=%h link=%h lane=%h",
                 k, countersComparators, rxLinkNum, rxLaneNum, e.comp, e.link, e.lane);
      else passed++;
    end
  endtask

  task automatic test_interrupted();
    for (int k = 0; k <= 16; k++) begin
      if (k == 0)      drive(1'b0, 16'h0, 2'b00, 1'b0, 1'b0, 8'd0, 8'd0, 16'h0, 8'd0, 8'd0);
      else if (k == 8) drive(1'b1, 16'h1, 2'b11, 1'b1, 1'b1, 8'd0, 8'd0, 16'h0, 8'd0, 8'd0);
      else             drive(1'b1, 16'h1, 2'b01, 1'b1, 1'b1, 8'd0, 8'd0, {15'b0, k == 16}, 8'd0, 8'd0);
      e = sbQ.pop_front();
      total++;
      if ({countersComparators, rxLinkNum, rxLaneNum} !== {e.comp, 120'b0, e.link, 120'b0, e.lane})
        $display("FAIL interrupted step %0d: comp=%h link=%h lane=%h, expected comp=%h link=%h lane=%h",
                 k, countersComparators, rxLinkNum, rxLaneNum, e.comp, e.link, e.lane);
      else passed++;
    end
  endtask

  task automatic test_refchange();
    substate = 4'd6;
    comparatorsCount = 5'd2;
    for (int k = 0; k <= 3; k++) begin
      if (k == 0) drive(1'b0, 16'h1, 2'b00, 1'b0, 1'b0, 8'd0, 8'd0, 16'h0, 8'd0, 8'd0);
      else        drive(1'b1, 16'h1, 2'b01, 1'b0, 1'b0, (k == 1) ? 8'd5 : 8'd6, 8'd0,
                        {15'b0, k == 3}, (k == 1) ? 8'd5 : 8'd6, 8'd0);
      e = sbQ.pop_front();
      total++;
      if ({countersComparators, rxLinkNum, rxLaneNum} !== {e.comp, 120'b0, e.link, 120'b0, e.lane})
        $display("FAIL refchange step %0d: comp=%h link=%h lane=%h, expected comp=%h link=%h lane=%h",
                 k, countersComparators, rxLinkNum, rxLaneNum, e.comp, e.link, e.lane);
      else passed++;
    end
  endtask

  task automatic test_saturate();
    comparatorsCount = 5'd8;
    for (int k = 0; k <= 42; k++) begin
      if (k == 0) drive(1'b0, 16'h0, 2'b00, 1'b0, 1'b0, 8'd0, 8'd0, 16'h0, 8'd6, 8'd0);
      else if (k <= 40)
        drive(1'b1, 16'h1, 2'b01, 1'b0, 1'b0, 8'd6, 8'd3, {15'b0, k >= 8}, 8'd6, 8'd3);
      else begin
        comparatorsCount = 5'd31;
        drive(1'b0, 16'h1, 2'b00, 1'b0, 1'b0, 8'd0, 8'd0, 16'h1, 8'd6, 8'd3);
      end
      e = sbQ.pop_front();
      total++;
      if ({countersComparators, rxLinkNum, rxLaneNum} !== {e.comp, 120'b0, e.link, 120'b0, e.lane})
        $display("FAIL saturate step %0d: comp=%h link=%h lane=%h, expected comp=%h link=%h lane=%h",
                 k, countersComparators, rxLinkNum, rxLaneNum, e.comp, e.link, e.lane);
      else passed++;
    end
  endtask

  task automatic test_drop_clear();
    comparatorsCount = 5'd5;
    for (int k = 0; k <= 9; k++) begin
      if (k == 0)      drive(1'b0, 16'h0, 2'b00, 1'b0, 1'b0, 8'd0, 8'd0, 16'h0, 8'd6, 8'd3);
      else if (k == 6) drive(1'b1, 16'h0, 2'b01, 1'b0, 1'b0, 8'd9, 8'd9, 16'h0, 8'd6, 8'd3);
      else if (k == 7) drive(1'b0, 16'h1, 2'b00, 1'b0, 1'b0, 8'd0, 8'd0, 16'h0, 8'd6, 8'd3);
      else             drive(1'b1, 16'h1, 2'b01, 1'b0, 1'b0, 8'd6, 8'd3, {15'b0, k == 5}, 8'd6, 8'd3);
      e = sbQ.pop_front();
      total++;
      if ({countersComparators, rxLinkNum, rxLaneNum} !== {e.comp, 120'b0, e.link, 120'b0, e.lane})
        $display("FAIL drop_clear step %0d: comp=%h link=%h lane=%h, expected comp=%h link=%h lane=%h",
                 k, countersComparators, rxLinkNum, rxLaneNum, e.comp, e.link, e.lane);
      else passed++;
    end
  endtask

  task automatic test_substate_change();
    laneMask = 16'hFFFF;
    substate = 4'd2;
    comparatorsCount = 5'd8;
    for (int k = 0; k <= 18; k++) begin
      if (k == 9) substate = 4'd3;
      if (k == 0)       drive(1'b0, 16'h1, 2'b00, 1'b0, 1'b0, 8'd0, 8'd0, 16'h0, 8'd6, 8'd3);
      else if (k <= 8)  drive(1'b1, 16'h1, 2'b01, 1'b1, 1'b1, 8'd0, 8'd0, {15'b0, k == 8}, 8'd0, 8'd0);
      else if (k == 9)  drive(1'b0, 16'h1, 2'b00, 1'b0, 1'b0, 8'd0, 8'd0, 16'h0, 8'd0, 8'd0);
      else if (k <= 17) drive(1'b1, 16'h1, 2'b10, 1'b1, 1'b1, 8'd0, 8'd0, {15'b0, k == 17}, 8'd0, 8'd0);
      else              drive(1'b0, 16'h1, 2'b00, 1'b0, 1'b0, 8'd0, 8'd0, 16'h1, 8'd0, 8'd0);
      e = sbQ.pop_front();
      total++;
      if ({countersComparators, rxLinkNum, rxLaneNum} !== {e.comp, 120'b0, e.link, 120'b0, e.lane})
        $display("FAIL substate_change step %0d: comp=%h link=%h lane=%h, expected comp=%h link=%h lane=%h",
                 k, countersComparators, rxLinkNum, rxLaneNum, e.comp, e.link, e.lane);
      else passed++;
    end
    laneMask = 16'h0001;
  endtask

  task automatic test_zero_threshold();
    substate = 4'd9;
    comparatorsCount = 5'd0;
    for (int k = 0; k <= 3; k++) begin
      if (k == 2) comparatorsCount = 5'd1;
      if (k == 0)      drive(1'b0, 16'h0, 2'b00, 1'b0, 1'b0, 8'd0, 8'd0, 16'h0, 8'd0, 8'd0);
      else if (k == 1) drive(1'b0, 16'h1, 2'b00, 1'b0, 1'b0, 8'd0, 8'd0, 16'h1, 8'd0, 8'd0);
      else if (k == 2) drive(1'b1, 16'h1, 2'b01, 1'b0, 1'b0, 8'd7, 8'd7, 16'h0, 8'd0, 8'd0);
      else             drive(1'b1, 16'h1, 2'b10, 1'b1, 1'b1, 8'd7, 8'd7, 16'h0, 8'd0, 8'd0);
      e = sbQ.pop_front();
      total++;
      if ({countersComparators, rxLinkNum, rxLaneNum} !== {e.comp, 120'b0, e.link, 120'b0, e.lane})
        $display("FAIL zero_threshold step %0d: comp=%h link=%h lane=%h, expected comp=%h link=%h lane=%h",
                 k, countersComparators, rxLinkNum, rxLaneNum, e.comp, e.link, e.lane);
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    @(posedge clk);
    #1;
    test_threshold();
    test_interrupted();
    test_refchange();
    test_saturate();
    test_drop_clear();
    test_substate_change();
    test_zero_threshold();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
